// File: rtl/alu_mul_seq.sv
// Unsigned WIDTH x WIDTH shift-and-add multiplier sequencer that borrows the
// shared ALU adder, retiring one multiplier bit per clock.
module alu_mul_seq #(
  parameter int unsigned WIDTH  = 16,
  parameter logic [3:0]  OP_ADD = 4'b0100,
  parameter int unsigned CNT_W  = 5
) (
  input  logic               Clock,
  input  logic               Resetn,
  input  logic               Start,
  input  logic [WIDTH-1:0]   Multiplicand,
  input  logic [WIDTH-1:0]   Multiplier,
  output logic               Busy,
  output logic               Done,
  output logic [2*WIDTH-1:0] Product,
  output logic [WIDTH-1:0]   AluA,
  output logic [WIDTH-1:0]   AluB,
  output logic               AluAInvert,
  output logic [3:0]         AluOp,
  input  logic [WIDTH-1:0]   AluResult,
  input  logic               AluCarryOut
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [2*WIDTH-1:0] shifted;
  logic               run;

  assign run = (state_q == S_RUN);

  // {carry, sum, Q} shifted right by one: carry lands in Acc MSB, sum LSB in Q MSB.
  assign shifted = {AluCarryOut, AluResult, q_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    q_d     = q_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          m_d     = Multiplicand;
          q_d     = Multiplier;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        {acc_d, q_d} = shifted;
        cnt_d        = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = S_DONE;
          prod_d  = shifted;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      q_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end

  assign Busy       = (state_q != S_IDLE);
  assign Done       = (state_q == S_DONE);
  assign Product    = prod_q;
  assign AluA       = run ? acc_q : '0;
  assign AluB       = (run && q_q[0]) ? m_q : '0;
  assign AluAInvert = 1'b0;
  assign AluOp      = OP_ADD;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed bench for alu_mul_seq with a behavioural 16-bit ALU adder attached.
module tb_alu_mul_seq;

  logic        Clock = 1'b0;
  logic        Resetn;
  logic        Start;
  logic [15:0] Multiplicand;
  logic [15:0] Multiplier;
  logic        Busy;
  logic        Done;
  logic [31:0] Product;
  logic [15:0] AluA;
  logic [15:0] AluB;
  logic        AluAInvert;
  logic [3:0]  AluOp;
  logic [15:0] AluResult;
  logic        AluCarryOut;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clock = ~Clock;

  assign {AluCarryOut, AluResult} =
    {1'b0, (AluAInvert ? ~AluA : AluA)} + {1'b0, AluB};

  alu_mul_seq #(.WIDTH(16), .OP_ADD(4'b0100), .CNT_W(5)) dut (
    .Clock       (Clock),
    .Resetn      (Resetn),
    .Start       (Start),
    .Multiplicand(Multiplicand),
    .Multiplier  (Multiplier),
    .Busy        (Busy),
    .Done        (Done),
    .Product     (Product),
    .AluA        (AluA),
    .AluB        (AluB),
    .AluAInvert  (AluAInvert),
    .AluOp       (AluOp),
    .AluResult   (AluResult),
    .AluCarryOut (AluCarryOut)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // One full multiply: accept edge, 16 RUN cycles, DONE cycle, return to IDLE.
  // With hold set, Start stays high and operands are scrambled after acceptance.
  task automatic mul_op(input logic [15:0] m, input logic [15:0] q,
                        input logic [31:0] exp, input bit hold);
    logic [15:0] qm;
    qm           = q;
    Multiplicand = m;
    Multiplier   = q;
    Start        = 1'b1;
    tick();
    if (!hold) Start = 1'b0;
    Multiplicand = ~m;
    Multiplier   = ~q;
    for (int i = 0; i < 16; i++) begin
      check("busy_run", {31'd0, Busy}, 32'd1);
      check("done_run", {31'd0, Done}, 32'd0);
      check("aluop_run", {28'd0, AluOp}, 32'h4);
      check("alub_run", {16'd0, AluB}, qm[i] ? {16'd0, m} : 32'd0);
      tick();
    end
    check("done_pulse", {31'd0, Done}, 32'd1);
    check("busy_done", {31'd0, Busy}, 32'd1);
    check("product", Product, exp);
    tick();
    check("done_after", {31'd0, Done}, 32'd0);
    check("busy_idle", {31'd0, Busy}, 32'd0);
    check("product_hold", Product, exp);
  endtask

  initial begin
    Resetn       = 1'b0;
    Start        = 1'b0;
    Multiplicand = '0;
    Multiplier   = '0;
    #2;
    check("rst_busy", {31'd0, Busy}, 32'd0);
    check("rst_done", {31'd0, Done}, 32'd0);
    check("rst_product", Product, 32'd0);
    check("rst_alua", {16'd0, AluA}, 32'd0);
    check("rst_alub", {16'd0, AluB}, 32'd0);
    check("rst_ainv", {31'd0, AluAInvert}, 32'd0);
    check("rst_aluop", {28'd0, AluOp}, 32'h4);
    tick();
    tick();
    Resetn = 1'b1;
    tick();

    mul_op(16'd3, 16'd5, 32'h0000_000F, 1'b0);
    mul_op(16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 1'b0);
    mul_op(16'h0000, 16'h1234, 32'h0000_0000, 1'b0);
    mul_op(16'h1234, 16'h0001, 32'h0000_1234, 1'b0);

    // Start held high: back-to-back accepts exactly 18 edges apart.
    mul_op(16'h00FF, 16'h0101, 32'h0000_FFFF, 1'b1);
    mul_op(16'hABCD, 16'h0002, 32'h0001_579A, 1'b1);
    mul_op(16'h8000, 16'h8000, 32'h4000_0000, 1'b1);
    Start = 1'b0;
    tick();

    // Async reset in the middle of RUN discards the operation.
    Multiplicand = 16'd40000;
    Multiplier   = 16'd3;
    Start        = 1'b1;
    tick();
    Start = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check("pre_rst_busy", {31'd0, Busy}, 32'd1);
    #2;
    Resetn = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, Busy}, 32'd0);
    check("mid_rst_done", {31'd0, Done}, 32'd0);
    check("mid_rst_product", Product, 32'd0);
    tick();
    Resetn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("post_rst_done", {31'd0, Done}, 32'd0);
      check("post_rst_busy", {31'd0, Busy}, 32'd0);
    end
    mul_op(16'd7, 16'd9, 32'd63, 1'b0);

    mul_op(16'd100, 16'd85, 32'd8500, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_product", Product, 32'd8500);
      check("idle_done", {31'd0, Done}, 32'd0);
      check("idle_alua", {16'd0, AluA}, 32'd0);
      check("idle_alub", {16'd0, AluB}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
